// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the async FIFO read-domain port.
package async_fifo_pkg;

    localparam int RDPORT_BUF_DEPTH = 2;
    localparam int PERF_CNT_W       = 16;

    typedef logic [1:0] rdport_cnt_t;

    // Saturating increment used by the optional performance counters.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/rdport_skid_buf.sv
// Two-entry output buffer for the read port: enqueue at wr_ptr, dequeue at rd_ptr.
module rdport_skid_buf
    import async_fifo_pkg::*;
#(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             enq,
    input  logic [DSIZE-1:0] wdata,
    input  logic             deq,
    output logic [DSIZE-1:0] rdata,
    output logic             valid,
    output rdport_cnt_t      cnt
);

    logic [DSIZE-1:0] entry [RDPORT_BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    rdport_cnt_t      cnt_q;

    // NOTE: the entries are reset because m_data must read 0 out of reset;
    // with only two words this costs nothing and keeps the head deterministic.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            for (int i = 0; i < RDPORT_BUF_DEPTH; i++) begin
                entry[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (enq) begin
                entry[wr_ptr] <= wdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt_q <= cnt_q + {1'b0, enq} - {1'b0, deq};
        end
    end

    assign rdata = entry[rd_ptr];
    assign valid = (cnt_q != '0);
    assign cnt   = cnt_q;

endmodule

// File: rtl/async_fifo_rd_port.sv
// Read-domain endpoint of the async FIFO: pops into a 2-entry buffer and presents a valid/ready stream.
// Optional stall/beat counters are enabled by defining ASYNC_FIFO_RD_PORT_PERF_EN.
module async_fifo_rd_port
    import async_fifo_pkg::*;
#(
    parameter int DSIZE       = 8,
    parameter     FALLTHROUGH = "TRUE"
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  fifo_rempty,
    input  logic [DSIZE-1:0]      fifo_rdata,
    output logic                  fifo_rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DSIZE-1:0]      m_data,
    output logic [1:0]            occupancy
`ifdef ASYNC_FIFO_RD_PORT_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] beat_cnt
`endif
);

    localparam bit FWFT = (FALLTHROUGH == "TRUE");

    logic        live;
    logic        inflight;
    logic        enq;
    logic        deq;
    rdport_cnt_t cnt;
    logic [2:0]  demand;

    // NOTE: every flop is written with <= so all state updates see the
    // pre-edge values of each other, regardless of block ordering.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    assign deq = m_valid && m_ready;

    // Words already buffered plus the one in flight, minus the one leaving now;
    // three bits so the sum never wraps.
    assign demand    = {1'b0, cnt} + {2'b0, inflight} - {2'b0, deq};
    assign fifo_rinc = live && !fifo_rempty && (demand < 3'd2);

    generate
        if (FWFT) begin : g_fwft
            assign inflight = 1'b0;
            assign enq      = fifo_rinc;
        end else begin : g_registered
            always_ff @(posedge rclk or negedge rrst_n) begin
                if (!rrst_n) begin
                    inflight <= 1'b0;
                end else begin
                    inflight <= fifo_rinc;
                end
            end
            assign enq = inflight;
        end
    endgenerate

    rdport_skid_buf #(
        .DSIZE (DSIZE)
    ) u_buf (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .enq    (enq),
        .wdata  (fifo_rdata),
        .deq    (deq),
        .rdata  (m_data),
        .valid  (m_valid),
        .cnt    (cnt)
    );

    assign occupancy = cnt;

`ifdef ASYNC_FIFO_RD_PORT_PERF_EN
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            stall_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (m_valid && !m_ready) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (deq) begin
                beat_cnt <= sat_inc(beat_cnt);
            end
        end
    end
`endif

endmodule
